multi_line_capture_buffer: RTL and testbench
============================================

// Module: multi_line_capture_buffer
// PURPOSE
// Successor to the single-line buffer. Captures LINES consecutive sensor lines starting
// at a programmable START_LINE into one bank of a ping-pong memory. The reader drains the
// other bank without stalling the sensor. Sits between the MT9V034 pixel deserialiser
// and the line-processing logic; the whole block runs in the pixel clock domain.
// PARAMETERS
// PIX_W  10   pixel width in bits
// H      752  columns per line (pixels)
// V      480  lines per frame
// LINES  4    consecutive lines captured per frame (1..V)
// PORTS
// CLK            in   1              pixel clock; all logic on posedge
// RST_N          in   1              reset, asynchronous assert, active-low
// VALID_DATA     in   1              DATA_IN is a valid pixel this cycle
// CURRENT_COLUMN in   $clog2(H)      column index of DATA_IN
// CURRENT_LINE   in   $clog2(V)      line index of DATA_IN
// START_LINE     in   $clog2(V)      first line to capture
// DATA_IN        in   PIX_W          pixel value
// READ_LINE      in   $clog2(LINES)  line within the ready bank (0..LINES-1); width 1 when LINES=1
// READ_ADDRESS   in   $clog2(H)      column within the ready bank
// RELEASE        in   1              reader finished; frees the read bank
// READY_FLAG     out  1              read bank holds a complete capture
// OVERRUN        out  1              1-cycle pulse: capture discarded because read bank still held
// DATA_OUT       out  PIX_W          registered read data
// BEHAVIOUR
// - Reset (RST_N=0, async): DATA_OUT=0, READY_FLAG=0, OVERRUN=0, FSM=ARM, write bank wb=0.
//   Memory contents are not cleared. A reset mid-capture abandons that capture.
// - Memory: 2 banks x LINES x H words of PIX_W. Writer uses bank wb; reader uses bank ~wb.
// - Window: in_win = (CURRENT_LINE >= s) && (CURRENT_LINE - s < LINES), where s is the
//   START_LINE latched on entry to REC. Compare with widths extended by 1 bit; no wrap
//   past V-1 (a window that runs off the frame end is truncated).
// - FSM, state updated every CLK:
//   ARM: wait until CURRENT_LINE != START_LINE -> IDLE. Never start mid-line.
//   IDLE: CURRENT_LINE == START_LINE -> REC, latch s = START_LINE.
//   REC: while in_win, each VALID_DATA with CURRENT_COLUMN < H writes DATA_IN to
//        bank wb[CURRENT_LINE - s][CURRENT_COLUMN]. Columns >= H are dropped.
//        The first cycle CURRENT_LINE leaves the window -> COMMIT.
//   COMMIT (1 cycle):
//        if READY_FLAG==0, or RELEASE==1 this cycle: toggle wb, set READY_FLAG=1.
//        otherwise: no swap, OVERRUN=1 for this cycle, capture discarded.
//        Then -> ARM.
// - The pixel on the cycle REC is entered is written (same-cycle entry).
//   Lines inside the window that carry no VALID_DATA leave stale words.
// - READY_FLAG: set only in COMMIT; cleared on the cycle after RELEASE=1.
//   RELEASE while READY_FLAG=0 has no effect.
//   RELEASE and COMMIT in the same cycle: the release frees the bank first, so the
//   commit succeeds and READY_FLAG stays 1 for the new bank.
// - Read: DATA_OUT <= bank ~wb [READ_LINE][READ_ADDRESS] every cycle, 1-cycle latency,
//   independent of READY_FLAG. READ_LINE >= LINES or READ_ADDRESS >= H gives DATA_OUT=0.
//   On the swap cycle the read bank changes; the read in the following cycle sees the new bank.
// - START_LINE changes are ignored outside IDLE.
// - Reads and writes never target the same bank, so there are no read/write collisions.
// TESTING
// 1 Reset: hold RST_N=0 -> READY_FLAG=0, OVERRUN=0, DATA_OUT=0; release, no stimulus -> no flags.
// 2 Basic capture: LINES=4, START_LINE=100; drive a frame with DATA_IN=(line*8+col)&0x3FF
//   -> READY_FLAG=1 the cycle after line 104 begins; READ_LINE=2, READ_ADDRESS=5 gives
//   (102*8+5)&0x3FF one cycle later.
// 3 Overrun: hold RELEASE=0 across 2 frames -> frame-2 COMMIT pulses OVERRUN once;
//   readback still shows frame-1 data.
// 4 Same-cycle RELEASE+COMMIT: READY_FLAG=1 and RELEASE asserted exactly on COMMIT
//   -> no OVERRUN, READY_FLAG stays 1, readback shows the new frame.
// 5 Boundaries: START_LINE=478, LINES=4 -> lines 478 and 479 captured; COMMIT occurs on
//   wrap to line 0. Column 760 (>= H) is dropped. READ_LINE=LINES -> DATA_OUT=0.
// 6 Mid-capture reset: RST_N low during line 101 -> flags 0; the next frame captures cleanly
//   with no partial data exposed.

Source files
------------

// File: rtl/multi_line_capture_buffer_if.sv
// Sensor-side capture and reader-side drain signals of the multi-line capture buffer.
interface multi_line_capture_buffer_if #(
    parameter int PIX_W = 10,
    parameter int H     = 752,
    parameter int V     = 480,
    parameter int LINES = 4
);
    localparam int CW  = $clog2(H);
    localparam int LNW = $clog2(V);
    localparam int LW  = (LINES > 1) ? $clog2(LINES) : 1;

    logic             valid_data;
    logic [CW-1:0]    current_column;
    logic [LNW-1:0]   current_line;
    logic [LNW-1:0]   start_line;
    logic [PIX_W-1:0] data_in;
    logic [LW-1:0]    read_line;
    logic [CW-1:0]    read_address;
    logic             release_bank;
    logic             ready_flag;
    logic             overrun;
    logic [PIX_W-1:0] data_out;

    modport master (
        output valid_data, current_column, current_line, start_line, data_in,
        output read_line, read_address, release_bank,
        input  ready_flag, overrun, data_out
    );

    modport slave (
        input  valid_data, current_column, current_line, start_line, data_in,
        input  read_line, read_address, release_bank,
        output ready_flag, overrun, data_out
    );
endinterface

// File: rtl/multi_line_capture_buffer.sv
// Captures LINES consecutive sensor lines from a programmable start line into one half of a
// ping-pong memory while the reader drains the other half.
module multi_line_capture_buffer #(
    parameter int PIX_W = 10,
    parameter int H     = 752,
    parameter int V     = 480,
    parameter int LINES = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    multi_line_capture_buffer_if.slave   bus
);
    localparam int CW         = $clog2(H);
    localparam int LNW        = $clog2(V);
    localparam int LW         = (LINES > 1) ? $clog2(LINES) : 1;
    localparam int BANK_DEPTH = LINES * H;
    localparam int BAW        = $clog2(BANK_DEPTH);

    typedef enum logic [1:0] {
        ST_ARM,
        ST_IDLE,
        ST_REC,
        ST_COMMIT
    } state_t;

    state_t           state_reg, state_next;
    logic             wb_reg, wb_next;
    logic             ready_reg, ready_next;
    logic [LNW-1:0]   s_reg, s_next;
    logic             rd_ok_reg;
    logic             rd_bank_reg;

    logic [LNW:0]     line_x;
    logic [LNW:0]     s_x;
    logic [LNW:0]     line_off;
    logic             in_win;
    logic             col_ok;
    logic             rd_ok;
    logic             we;
    logic             overrun_c;
    logic [LW-1:0]    wr_row;
    logic [BAW-1:0]   wr_addr;
    logic [BAW-1:0]   rd_addr;
    logic [1:0][PIX_W-1:0] bank_q;

    // One extra bit keeps line - s from wrapping when the line is below the window.
    assign line_x   = {1'b0, bus.current_line};
    assign s_x      = {1'b0, s_reg};
    assign line_off = line_x - s_x;
    assign in_win   = (line_x >= s_x) && (int'(line_off) < LINES);
    assign col_ok   = int'(bus.current_column) < H;
    assign rd_ok    = (int'(bus.read_line) < LINES) && (int'(bus.read_address) < H);

    assign wr_addr = BAW'(int'(wr_row) * H + int'(bus.current_column));
    assign rd_addr = rd_ok ? BAW'(int'(bus.read_line) * H + int'(bus.read_address)) : '0;

    always_comb begin
        state_next = state_reg;
        wb_next    = wb_reg;
        ready_next = ready_reg;
        s_next     = s_reg;
        we         = 1'b0;
        wr_row     = '0;
        overrun_c  = 1'b0;

        if (bus.release_bank && ready_reg) begin
            ready_next = 1'b0;
        end

        case (state_reg)
            ST_ARM: begin
                // Never begin a capture part-way through the start line.
                if (bus.current_line != bus.start_line) begin
                    state_next = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (bus.current_line == bus.start_line) begin
                    state_next = ST_REC;
                    s_next     = bus.start_line;
                    we         = bus.valid_data && col_ok;
                end
            end
            ST_REC: begin
                if (in_win) begin
                    we     = bus.valid_data && col_ok;
                    wr_row = line_off[LW-1:0];
                end else begin
                    state_next = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                // A release in this same cycle frees the read bank, so the swap still goes ahead.
                if (!ready_reg || bus.release_bank) begin
                    wb_next    = ~wb_reg;
                    ready_next = 1'b1;
                end else begin
                    overrun_c = 1'b1;
                end
                state_next = ST_ARM;
            end
            default: begin
                state_next = ST_ARM;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_ARM;
            wb_reg      <= 1'b0;
            ready_reg   <= 1'b0;
            s_reg       <= '0;
            rd_ok_reg   <= 1'b0;
            rd_bank_reg <= 1'b1;
        end else begin
            state_reg   <= state_next;
            wb_reg      <= wb_next;
            ready_reg   <= ready_next;
            s_reg       <= s_next;
            rd_ok_reg   <= rd_ok;
            rd_bank_reg <= ~wb_reg;
        end
    end

    // Each bank is an independent block RAM; the write bank's read port output is simply unused.
    for (genvar gi = 0; gi < 2; gi++) begin : g_bank
        logic [PIX_W-1:0] mem [BANK_DEPTH];
        logic [PIX_W-1:0] q_reg;

        always_ff @(posedge clk) begin
            if (we && (wb_reg == 1'(gi))) begin
                mem[wr_addr] <= bus.data_in;
            end
            q_reg <= mem[rd_addr];
        end

        assign bank_q[gi] = q_reg;
    end

    assign bus.data_out   = rd_ok_reg ? bank_q[rd_bank_reg] : '0;
    assign bus.ready_flag = ready_reg;
    assign bus.overrun    = overrun_c;

endmodule

// File: tb/tb_multi_line_capture_buffer.sv
// Directed-frame bench for multi_line_capture_buffer with a frame-level reference model.
module tb_multi_line_capture_buffer;
    localparam int PIX_W = 10;
    localparam int H     = 752;
    localparam int V     = 480;
    localparam int LINES = 4;
    localparam int CW    = $clog2(H);
    localparam int LNW   = $clog2(V);
    localparam int LW    = (LINES > 1) ? $clog2(LINES) : 1;

    localparam int PH_ARMED  = 0;
    localparam int PH_WAIT   = 1;
    localparam int PH_CAP    = 2;
    localparam int PH_COMMIT = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    multi_line_capture_buffer_if #(.PIX_W(PIX_W), .H(H), .V(V), .LINES(LINES)) bus ();

    multi_line_capture_buffer #(.PIX_W(PIX_W), .H(H), .V(V), .LINES(LINES)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int ovr_dut  = 0;

    int rd_addrs [20] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15, 20, 751, 760, 1023};

    // Reference model: two frame images, which one is being filled, and capture progress.
    int  img [int];
    int  m_phase;
    int  m_s;
    bit  m_sel;
    bit  m_ready;
    int  m_dout;
    bit  m_known;

    function automatic int img_key(input bit bank, input int row, input int col);
        return (int'(bank) * LINES + row) * H + col;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        int  line, col, st, rl, ra;
        bit  rel, rdy_old, exp_ovr;
        if (!rst_n) begin
            m_phase = PH_ARMED;
            m_sel   = 1'b0;
            m_ready = 1'b0;
            m_dout  = 0;
            m_known = 1'b1;
            chk("rst_ready", int'(bus.ready_flag), 0);
            chk("rst_overrun", int'(bus.overrun), 0);
            chk("rst_data_out", int'(bus.data_out), 0);
        end else begin
            line = int'(bus.current_line);
            col  = int'(bus.current_column);
            st   = int'(bus.start_line);
            rel  = bus.release_bank;
            rl   = int'(bus.read_line);
            ra   = int'(bus.read_address);

            exp_ovr = (m_phase == PH_COMMIT) && m_ready && !rel;
            chk("ready_flag", int'(bus.ready_flag), int'(m_ready));
            chk("overrun", int'(bus.overrun), int'(exp_ovr));
            if (m_known) chk("data_out", int'(bus.data_out), m_dout);
            if (bus.overrun) ovr_dut++;

            // Read uses the bank that is readable before any swap at this edge.
            if (rl < LINES && ra < H) begin
                m_known = img.exists(img_key(!m_sel, rl, ra));
                m_dout  = m_known ? img[img_key(!m_sel, rl, ra)] : 0;
            end else begin
                m_known = 1'b1;
                m_dout  = 0;
            end

            rdy_old = m_ready;
            if (rel && m_ready) m_ready = 1'b0;

            case (m_phase)
                PH_ARMED:  if (line != st) m_phase = PH_WAIT;
                PH_WAIT: begin
                    if (line == st) begin
                        m_s     = st;
                        m_phase = PH_CAP;
                        if (bus.valid_data && col < H) img[img_key(m_sel, 0, col)] = int'(bus.data_in);
                    end
                end
                PH_CAP: begin
                    if (line >= m_s && line - m_s < LINES) begin
                        if (bus.valid_data && col < H) img[img_key(m_sel, line - m_s, col)] = int'(bus.data_in);
                    end else begin
                        m_phase = PH_COMMIT;
                    end
                end
                default: begin
                    if (!rdy_old || rel) begin
                        m_sel   = !m_sel;
                        m_ready = 1'b1;
                    end
                    m_phase = PH_ARMED;
                end
            endcase
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pix(input int line, input int col, input bit v, input int tag);
        bus.current_line   = LNW'(line);
        bus.current_column = CW'(col);
        bus.valid_data     = v;
        bus.data_in        = PIX_W'((line * 8 + col + tag * 37) & 1023);
        bus.read_line      = LW'($urandom_range(0, LINES - 1));
        bus.read_address   = CW'(rd_addrs[$urandom_range(0, 19)]);
        step();
    endtask

    task automatic drive_line(input int line, input int tag, input int rel_idx, input int rst_idx);
        int cols [$];
        bit full;
        full = (line >= 98 && line < 106) || line >= 476;
        cols = {};
        if (full) begin
            for (int c = 0; c < 16; c++) cols.push_back(c);
            cols.push_back(20);
            cols.push_back(760);
            cols.push_back(751);
        end else begin
            cols = '{0, 1, 2};
        end
        for (int i = 0; i < cols.size(); i++) begin
            bus.release_bank = (i == rel_idx);
            rst_n = (i != rst_idx);
            pix(line, cols[i], !(cols[i] == 20), tag);
            if (i == rst_idx) begin
                chk("midrst_ready", int'(bus.ready_flag), 0);
                chk("midrst_overrun", int'(bus.overrun), 0);
                chk("midrst_data_out", int'(bus.data_out), 0);
            end
        end
        bus.release_bank = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic drive_frame(input int tag, input int rel_line, input int rel_idx,
                               input int rst_line, input int rst_idx);
        for (int ln = 0; ln < V; ln++) begin
            drive_line(ln, tag, (ln == rel_line) ? rel_idx : -1, (ln == rst_line) ? rst_idx : -1);
        end
        bus.valid_data = 1'b0;
    endtask

    task automatic read_chk(input string name, input int rl, input int ra, input int exp);
        bus.valid_data   = 1'b0;
        bus.read_line    = LW'(rl);
        bus.read_address = CW'(ra);
        step();
        chk(name, int'(bus.data_out), exp);
    endtask

    task automatic sweep();
        bus.valid_data = 1'b0;
        for (int rl = 0; rl < LINES; rl++) begin
            for (int k = 0; k < 20; k++) begin
                bus.read_line    = LW'(rl);
                bus.read_address = CW'(rd_addrs[k]);
                step();
            end
        end
    endtask

    int ovr0;

    initial begin
        bus.valid_data     = 1'b0;
        bus.current_column = '0;
        bus.current_line   = '0;
        bus.start_line     = LNW'(100);
        bus.data_in        = '0;
        bus.read_line      = '0;
        bus.read_address   = '0;
        bus.release_bank   = 1'b0;
        rst_n              = 1'b0;
        repeat (3) step();
        chk("reset_ready", int'(bus.ready_flag), 0);
        chk("reset_data_out", int'(bus.data_out), 0);

        rst_n = 1'b1;
        repeat (20) step();
        chk("quiet_ready", int'(bus.ready_flag), 0);
        chk("quiet_overrun_count", ovr_dut, 0);

        // Basic capture of lines 100..103.
        drive_frame(0, -1, -1, -1, -1);
        chk("f1_ready", int'(bus.ready_flag), 1);
        read_chk("f1_l2_c5", 2, 5, 821);
        sweep();

        // Second frame with the first still held: discarded with one overrun pulse.
        ovr0 = ovr_dut;
        drive_frame(1, -1, -1, -1, -1);
        chk("f2_overrun_pulses", ovr_dut - ovr0, 1);
        chk("f2_ready", int'(bus.ready_flag), 1);
        read_chk("f2_keeps_f1", 2, 5, 821);

        // Release lands exactly on the commit cycle.
        ovr0 = ovr_dut;
        drive_frame(2, 104, 1, -1, -1);
        chk("f3_overrun_pulses", ovr_dut - ovr0, 0);
        chk("f3_ready", int'(bus.ready_flag), 1);
        read_chk("f3_new_frame", 2, 5, 895);
        sweep();

        bus.release_bank = 1'b1;
        step();
        bus.release_bank = 1'b0;
        chk("release_clears_ready", int'(bus.ready_flag), 0);

        // Window truncated at the frame end; commit happens on the wrap to line 0.
        bus.start_line = LNW'(478);
        drive_frame(3, -1, -1, -1, -1);
        chk("f4_ready_before_wrap", int'(bus.ready_flag), 0);
        for (int ln = 0; ln < 3; ln++) drive_line(ln, 3, -1, -1);
        bus.valid_data = 1'b0;
        chk("f4_ready", int'(bus.ready_flag), 1);
        read_chk("f4_l0_c7", 0, 7, 870);
        read_chk("f4_l1_c751", 1, 751, 598);
        read_chk("f4_col760_reads_zero", 0, 760, 0);
        read_chk("f4_col760_dropped", 2, 8, 824);
        read_chk("f4_addr1023_zero", 3, 1023, 0);
        sweep();

        // Reset in the middle of a capture, then a clean frame.
        bus.start_line = LNW'(100);
        drive_frame(4, -1, -1, 101, 2);
        chk("f5_ready_after_reset", int'(bus.ready_flag), 0);
        drive_frame(5, -1, -1, -1, -1);
        chk("f6_ready", int'(bus.ready_flag), 1);
        read_chk("f6_l2_c5", 2, 5, 1006);
        read_chk("f6_l0_c0", 0, 0, 985);
        sweep();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
